// File: rtl/bus_cycle_controller_pkg.sv
// Shared types and chip-select indices for the 8088 bus cycle controller.
package bus_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ADDR    = 4'b0010,
        XFER    = 4'b0100,
        RECOVER = 4'b1000
    } state_t;

    localparam int unsigned CS_MEM0 = 0;
    localparam int unsigned CS_MEM1 = 1;
    localparam int unsigned CS_IO0  = 2;
    localparam int unsigned CS_IO1  = 3;
    localparam int unsigned NUM_DEV = 4;

endpackage

// File: rtl/bus_cycle_controller_addr_decode.sv
// Combinational address decoder: CPU address and cycle type to one-hot chip select.
module bus_addr_decode
    import bus_ctrl_pkg::*;
#(
    parameter logic [19:0]  MEM0_BASE = 20'h00000,
    parameter logic [19:0]  MEM1_BASE = 20'hFC000,
    parameter int unsigned  MEM_SIZE  = 14,
    parameter logic [15:0]  IO0_BASE  = 16'hFF00,
    parameter logic [15:0]  IO1_BASE  = 16'h1C00,
    parameter int unsigned  IO_SIZE   = 4
) (
    input  logic [19:0]         A,
    input  logic                IOM,
    output logic [NUM_DEV-1:0]  CS,
    output logic                hit
);

    // Lower device index wins when windows overlap.
    always_comb begin
        CS = '0;
        if (IOM) begin
            if ((A[15:0] >> IO_SIZE) == (IO0_BASE >> IO_SIZE))
                CS[CS_IO0] = 1'b1;
            else if ((A[15:0] >> IO_SIZE) == (IO1_BASE >> IO_SIZE))
                CS[CS_IO1] = 1'b1;
        end else begin
            if ((A >> MEM_SIZE) == (MEM0_BASE >> MEM_SIZE))
                CS[CS_MEM0] = 1'b1;
            else if ((A >> MEM_SIZE) == (MEM1_BASE >> MEM_SIZE))
                CS[CS_MEM1] = 1'b1;
        end
        hit = |CS;
    end

endmodule

// File: rtl/bus_cycle_controller.sv
// 8088 bus cycle sequencer: latches the address on ALE, drives chip selects
// for the whole cycle and flags decode misses, strobe violations and stuck cycles.
module bus_cycle_controller
    import bus_ctrl_pkg::*;
#(
    parameter logic [19:0]  MEM0_BASE = 20'h00000,
    parameter logic [19:0]  MEM1_BASE = 20'hFC000,
    parameter int unsigned  MEM_SIZE  = 14,
    parameter logic [15:0]  IO0_BASE  = 16'hFF00,
    parameter logic [15:0]  IO1_BASE  = 16'h1C00,
    parameter int unsigned  IO_SIZE   = 4,
    parameter int unsigned  TIMEOUT   = 15
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ALE,
    input  logic                IOM,
    input  logic                RD_N,
    input  logic                WR_N,
    input  logic [19:0]         A,
    output logic [19:0]         Address,
    output logic [NUM_DEV-1:0]  CS,
    output logic                BusBusy,
    output logic                DecodeMiss,
    output logic                BusError
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t              state;
    logic [TW-1:0]       timer;
    logic [NUM_DEV-1:0]  cs_q;
    logic [NUM_DEV-1:0]  dec_cs;
    logic                dec_hit;
    logic                both_low;
    logic                one_low;

    bus_addr_decode #(
        .MEM0_BASE (MEM0_BASE),
        .MEM1_BASE (MEM1_BASE),
        .MEM_SIZE  (MEM_SIZE),
        .IO0_BASE  (IO0_BASE),
        .IO1_BASE  (IO1_BASE),
        .IO_SIZE   (IO_SIZE)
    ) u_decode (
        .A   (A),
        .IOM (IOM),
        .CS  (dec_cs),
        .hit (dec_hit)
    );

    assign both_low = !RD_N && !WR_N;
    assign one_low  = RD_N ^ WR_N;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            timer      <= '0;
            cs_q       <= '0;
            Address    <= '0;
            DecodeMiss <= 1'b0;
            BusError   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ALE) begin
                        Address <= IOM ? {4'h0, A[15:0]} : A;
                        cs_q    <= dec_cs;
                        timer   <= '0;
                        state   <= ADDR;
                        if (!dec_hit)
                            DecodeMiss <= 1'b1;
                    end
                end
                ADDR, XFER: begin
                    // Watchdog expiry and a double strobe end the cycle identically.
                    if (both_low || timer == TLAST) begin
                        BusError <= 1'b1;
                        cs_q     <= '0;
                        state    <= RECOVER;
                    end else begin
                        timer <= timer + 1'b1;
                        if (state == ADDR && one_low)
                            state <= XFER;
                        else if (state == XFER && RD_N && WR_N)
                            state <= RECOVER;
                    end
                end
                RECOVER: begin
                    cs_q  <= '0;
                    state <= IDLE;
                end
                default: begin
                    cs_q  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Devices sample CS together with ALE, so the ALE cycle sees the live decode.
    assign CS      = (state == IDLE && ALE) ? dec_cs : cs_q;
    assign BusBusy = (state != IDLE) || ALE;

endmodule
